viterbi_decoder: RTL and testbench

VITERBI_DECODER -- requirements
Module: viterbi_decoder

---
 rtl/viterbi_pkg.sv | 25 ++
 rtl/viterbi_acs.sv | 26 ++
 rtl/viterbi_encoder.sv | 24 ++
 rtl/viterbi_decoder.sv | 93 +++++++++
 tb/tb_viterbi_decoder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants, state type and branch helpers for the K=3 rate-1/2 code
package viterbi_pkg;

  localparam int         K        = 3;
  localparam logic [2:0] G0       = 3'b111;
  localparam logic [2:0] G1       = 3'b101;
  localparam int         TB_DEPTH = 16;
  localparam int         PM_W     = 4;

  typedef logic [1:0] state_t;

  // Encoder output for input bit a leaving state s; taps act on {x[n], x[n-1], x[n-2]}
  function automatic logic [1:0] branch_sym(input state_t s, input logic a);
    logic [2:0] w_taps;
    w_taps = {a, s};
    return {^(w_taps & G0), ^(w_taps & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] w_d;
    w_d = a ^ b;
    return {w_d[1] & w_d[0], w_d[1] ^ w_d[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// rtl/viterbi_acs.sv - add-compare-select for one trellis state, saturating adds, tie goes to pred 0
module viterbi_acs #(
  parameter int PM_W = 4
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [1:0]      i_bm0,
  input  logic [1:0]      i_bm1,
  output logic [PM_W-1:0] o_pm,
  output logic            o_dec
);

  logic [PM_W:0]   w_sum0;
  logic [PM_W:0]   w_sum1;
  logic [PM_W-1:0] w_cand0;
  logic [PM_W-1:0] w_cand1;

  assign w_sum0  = {1'b0, i_pm0} + (PM_W+1)'(i_bm0);
  assign w_sum1  = {1'b0, i_pm1} + (PM_W+1)'(i_bm1);
  assign w_cand0 = w_sum0[PM_W] ? '1 : w_sum0[PM_W-1:0];
  assign w_cand1 = w_sum1[PM_W] ? '1 : w_sum1[PM_W-1:0];

  assign o_dec = (w_cand1 < w_cand0);
  assign o_pm  = o_dec ? w_cand1 : w_cand0;

endmodule

// File: rtl/viterbi_encoder.sv
// rtl/viterbi_encoder.sv - reference K=3 convolutional encoder, symbol is combinational on x
module viterbi_encoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       x,
  output logic [1:0] y
);

  state_t r_state;

  assign y = branch_sym(r_state, x);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
    end else if (in_valid) begin
      r_state <= {x, r_state[1]};
    end
  end

endmodule

// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - hard-decision Viterbi decoder, register-exchange survivors, fixed decision depth
module viterbi_decoder #(
  parameter int TB_DEPTH = viterbi_pkg::TB_DEPTH,
  parameter int PM_W     = viterbi_pkg::PM_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] y,
  output logic       out_valid,
  output logic       x_out
);
  import viterbi_pkg::*;

  localparam int CNT_W = $clog2(TB_DEPTH + 1);

  logic [3:0][PM_W-1:0]     r_pm;
  logic [3:0][TB_DEPTH-1:0] r_surv;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_out_valid;
  logic                     r_x_out;

  logic [3:0][PM_W-1:0]     w_pm_new;
  logic [3:0]               w_dec;
  state_t [3:0]             w_pred;
  logic [3:0][TB_DEPTH-1:0] w_surv_new;
  logic [PM_W-1:0]          w_pm_min;
  state_t                   w_best;

  // Next state {a,b} is reached from {b,0} or {b,1} with input bit a
  for (genvar g = 0; g < 4; g++) begin : g_state
    localparam logic   A  = ((g / 2) == 1);
    localparam logic   B  = ((g % 2) == 1);
    localparam state_t P0 = {B, 1'b0};
    localparam state_t P1 = {B, 1'b1};

    logic [1:0] w_bm0;
    logic [1:0] w_bm1;

    assign w_bm0 = hamming2(y, branch_sym(P0, A));
    assign w_bm1 = hamming2(y, branch_sym(P1, A));

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .i_pm0 (r_pm[P0]),
      .i_pm1 (r_pm[P1]),
      .i_bm0 (w_bm0),
      .i_bm1 (w_bm1),
      .o_pm  (w_pm_new[g]),
      .o_dec (w_dec[g])
    );

    assign w_pred[g]     = {B, w_dec[g]};
    assign w_surv_new[g] = {r_surv[w_pred[g]][TB_DEPTH-2:0], A};
  end

  always_comb begin
    w_pm_min = w_pm_new[0];
    w_best   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (w_pm_new[i] < w_pm_min) begin
        w_pm_min = w_pm_new[i];
        w_best   = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pm        <= {PM_W'(3), PM_W'(3), PM_W'(3), PM_W'(0)};
      r_surv      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_x_out     <= 1'b0;
    end else if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
        r_pm[i] <= w_pm_new[i] - w_pm_min;
      end
      r_surv <= w_surv_new;
      if (r_cnt != CNT_W'(TB_DEPTH)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // r_cnt still counts the previous symbols, so this symbol is number r_cnt+1
      r_out_valid <= (r_cnt >= CNT_W'(TB_DEPTH - 1));
      r_x_out     <= w_surv_new[w_best][TB_DEPTH-1];
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign x_out     = r_x_out;

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - directed table and sequence bench for viterbi_decoder
module tb_viterbi_decoder;
  import viterbi_pkg::*;

  typedef struct {
    logic [1:0] y;
    logic       exp_v;
    logic       exp_x;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] tb_y;
  logic       use_enc;
  logic       enc_x;
  logic [1:0] enc_y;
  logic [1:0] w_y;
  logic       out_valid;
  logic       x_out;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vecs [26];

  always #5 clk = ~clk;

  assign w_y = use_enc ? enc_y : tb_y;

  viterbi_decoder #(.TB_DEPTH(16), .PM_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .y         (w_y),
    .out_valid (out_valid),
    .x_out     (x_out)
  );

  viterbi_encoder u_enc (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .x        (enc_x),
    .y        (enc_y)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic with_symbol);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = with_symbol;
    tb_y     = 2'b11;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_x"}, 32'(x_out), 32'd0);
    check({tag, "_pm"}, 32'(dut.r_pm), 32'h3330);
  endtask

  // Apply the reference stream; optional 3-cycle gaps and a corrupted third symbol
  task automatic run_table(input string tag, input logic gaps, input logic err);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      tb_y     = (err && i == 2) ? 2'b10 : vecs[i].y;
      #1;
      if (err && i == 2) check({tag, "_pm_win_s3"}, 32'(dut.w_pm_min), 32'd1);
      if (!err && i == 2) check({tag, "_pm_win_s3"}, 32'(dut.w_pm_min), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("%s_ov_%0d", tag, i + 1), 32'(out_valid), 32'(vecs[i].exp_v));
      check($sformatf("%s_x_%0d", tag, i + 1), 32'(x_out), 32'(vecs[i].exp_x));
      if (err && i == 2) check({tag, "_pm_s3"}, 32'(dut.r_pm), 32'h1020);
      if (gaps) begin
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          in_valid = 1'b0;
          tb_y     = 2'(j);
          @(posedge clk);
          #1;
          check($sformatf("%s_gap_ov_%0d_%0d", tag, i + 1, j), 32'(out_valid), 32'd0);
          check($sformatf("%s_gap_x_%0d_%0d", tag, i + 1, j), 32'(x_out), 32'(vecs[i].exp_x));
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] syms [6];
    logic [5:0] msg;
    int         bad;
    int         pulses;
    logic       bits [500];
    logic [PM_W-1:0] pm_min;

    syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    msg  = 6'b001101;
    for (int i = 0; i < 26; i++) begin
      vecs[i].y     = (i < 6) ? syms[i] : 2'b00;
      vecs[i].exp_v = (i >= 15);
      vecs[i].exp_x = (i >= 15 && (i - 15) < 6) ? msg[i-15] : 1'b0;
    end

    reset    = 1'b1;
    in_valid = 1'b0;
    tb_y     = 2'b00;
    use_enc  = 1'b0;
    enc_x    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b0;

    run_table("clean", 1'b0, 1'b0);

    do_reset(1'b1);
    check_reset_state("rst1");
    run_table("err", 1'b0, 1'b1);

    do_reset(1'b0);
    run_table("gap", 1'b1, 1'b0);

    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      tb_y     = vecs[i].y;
      @(posedge clk);
    end
    do_reset(1'b1);
    check_reset_state("mid");
    run_table("mid", 1'b0, 1'b0);

    do_reset(1'b0);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      tb_y     = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      pm_min = dut.r_pm[0];
      for (int s = 1; s < 4; s++) if (dut.r_pm[s] < pm_min) pm_min = dut.r_pm[s];
      if (pm_min != '0 || $isunknown(dut.r_pm) || $isunknown(out_valid) || $isunknown(x_out))
        bad++;
    end
    check("rand_norm_bad", 32'(bad), 32'd0);
    check("rand_ov_sat", 32'(out_valid), 32'd1);

    do_reset(1'b0);
    use_enc = 1'b1;
    bad     = 0;
    pulses  = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      enc_x    = 1'($urandom_range(0, 1));
      bits[i]  = enc_x;
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        if (i < 15 || x_out !== bits[i-15]) bad++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    use_enc  = 1'b0;
    check("loop_mismatch", 32'(bad), 32'd0);
    check("loop_pulses", 32'(pulses), 32'd485);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
